// File: rtl/debounce_edge.sv
// debounce_edge: per-channel debouncer with registered level, press and release pulses.
// Define DEBOUNCE_REPEAT_EN to add auto-repeat press pulses while a channel is held high.
module debounce_edge #(
  parameter int QUANTITY        = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [QUANTITY-1:0] syncro,
  output logic [QUANTITY-1:0] stable,
  output logic [QUANTITY-1:0] press,
  output logic [QUANTITY-1:0] released
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  if (DEBOUNCE_CYCLES < 1) begin : g_bad
    $error("debounce_edge: DEBOUNCE_CYCLES must be >= 1");
  end
  for (genvar i = 0; i < QUANTITY; i++) begin : g_ch
    logic st, pr, rl, acc, rpt;
    logic [CW-1:0] cnt;
    // cnt holds the number of differing samples already seen, so the Nth one accepts
    assign acc = (syncro[i] != st) && (cnt == LAST);
`ifdef DEBOUNCE_REPEAT_EN
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW = $clog2(HMAX + 1);
    logic [HW-1:0] hold;
    logic rep;
    // first target is the initial delay, every later one is the period
    assign rpt = st && !acc && (hold + HW'(1) == (rep ? HW'(REPEAT_PERIOD) : HW'(REPEAT_DELAY)));
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold <= '0;
        rep  <= 1'b0;
      end else begin
        hold <= (!st || acc || rpt) ? '0 : hold + HW'(1);
        rep  <= (!st || acc) ? 1'b0 : (rpt ? 1'b1 : rep);
      end
    end
`else
    assign rpt = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st  <= 1'b0;
        pr  <= 1'b0;
        rl  <= 1'b0;
        cnt <= '0;
      end else begin
        pr  <= (acc && !st) || rpt;
        rl  <= acc && st;
        st  <= acc ? !st : st;
        cnt <= (syncro[i] == st || acc) ? '0 : cnt + CW'(1);
      end
    end
    assign stable[i]   = st;
    assign press[i]    = pr;
    assign released[i] = rl;
  end
endmodule
